// File: rtl/vec_logit_if.sv
// Handshake bundle for vec_logit: request side carries probabilities, response side carries logits.
// The master modport is the producer/consumer around the unit; the slave modport is the unit itself.
interface vec_logit_if #(
    parameter int W = 4,
    parameter int N = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [W-1:0][N-1:0]   y_arr;
    logic                  out_valid;
    logic                  out_ready;
    logic [W-1:0][N-1:0]   x_arr;
    logic                  busy;

    modport master (
        output in_valid,
        output y_arr,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  x_arr,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  y_arr,
        input  out_ready,
        output in_ready,
        output out_valid,
        output x_arr,
        output busy
    );
endinterface

// File: rtl/vec_logit.sv
// Vector inverse sigmoid by per-lane successive approximation over the forward sigmoid_unit.
// Optional macro VEC_LOGIT_BACK2BACK_EN lets a new vector be accepted while the previous result retires.
module sigmoid_unit #(
    parameter int N = 16,
    parameter int R = 8
) (
    input  logic [N-1:0] i_x,
    output logic [N-1:0] o_y
);
    localparam logic [N:0] ONE     = (N+1)'(1) << R;
    localparam logic [N:0] TWO     = ONE << 1;
    localparam logic [N:0] FOUR    = ONE << 2;
    localparam logic [N:0] HALF    = ONE >> 1;
    localparam logic [N:0] QUARTER = ONE >> 2;
    localparam logic [N:0] EIGHTH  = ONE >> 3;

    logic [N:0] w_abs;
    logic [N:0] w_f;

    // Continuous, monotone piecewise-linear curve on |x|; negative side mirrored as 1 - f(|x|)
    always_comb begin
        w_abs = i_x[N-1] ? ((~{1'b1, i_x}) + (N+1)'(1)) : {1'b0, i_x};
        if (w_abs < ONE) begin
            w_f = HALF + (w_abs >> 2);
        end else if (w_abs < TWO) begin
            w_f = (ONE - QUARTER) + ((w_abs - ONE) >> 3);
        end else if (w_abs < FOUR) begin
            w_f = (ONE - EIGHTH) + ((w_abs - TWO) >> 4);
        end else begin
            w_f = ONE;
        end
        o_y = i_x[N-1] ? N'(ONE - w_f) : N'(w_f);
    end
endmodule

module vec_logit #(
    parameter int W = 4,
    parameter int N = 16,
    parameter int R = 8
) (
    input  logic         clock,
    input  logic         reset,
    vec_logit_if.slave   bus
);
    localparam int KW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [KW-1:0]       r_k;
    logic [W-1:0][N-1:0] r_y;
    logic [W-1:0][N-1:0] r_u;
    logic [W-1:0][N-1:0] r_x;

    logic                w_accept;
    logic                w_inReady;
    logic                w_outValid;
    logic                w_busy;
    logic [N-1:0]        w_bitMask;
    logic [W-1:0][N-1:0] w_trial;
    logic [W-1:0][N-1:0] w_probe;
    logic [W-1:0][N-1:0] w_sig;
    logic [W-1:0][N-1:0] w_nextU;
    logic [W-1:0][N-1:0] w_nextX;

    assign w_bitMask = {{(N-1){1'b0}}, 1'b1} << r_k;

    // The accumulator is offset-binary so the search is a plain unsigned SAR; flipping the MSB gives two's complement
    genvar g;
    for (g = 0; g < W; g++) begin : gLane
        assign w_trial[g] = r_u[g] | w_bitMask;
        assign w_probe[g] = {~w_trial[g][N-1], w_trial[g][N-2:0]};

        sigmoid_unit #(.N(N), .R(R)) uSigmoid (
            .i_x (w_probe[g]),
            .o_y (w_sig[g])
        );

        assign w_nextU[g] = ($signed(w_sig[g]) <= $signed(r_y[g])) ? w_trial[g] : r_u[g];
        assign w_nextX[g] = {~w_nextU[g][N-1], w_nextU[g][N-2:0]};
    end

    always_comb begin
        w_nextState = r_state;
        w_inReady   = 1'b0;
        w_outValid  = 1'b0;
        w_busy      = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                w_inReady = 1'b1;
                if (bus.in_valid) begin
                    w_accept    = 1'b1;
                    w_nextState = SEARCH;
                end
            end
            SEARCH: begin
                w_busy = 1'b1;
                if (r_k == '0) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_busy     = 1'b1;
                w_outValid = 1'b1;
                if (bus.out_ready) begin
                    w_nextState = IDLE;
`ifdef VEC_LOGIT_BACK2BACK_EN
                    w_inReady = 1'b1;
                    if (bus.in_valid) begin
                        w_accept    = 1'b1;
                        w_nextState = SEARCH;
                    end
`endif
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // x_arr is only rewritten when the final bit resolves, so a retiring result stays put during a new search
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_k     <= KW'(N-1);
            r_y     <= '0;
            r_u     <= '0;
            r_x     <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_accept) begin
                r_y <= bus.y_arr;
                r_u <= '0;
                r_k <= KW'(N-1);
            end else if (r_state == SEARCH) begin
                r_u <= w_nextU;
                if (r_k == '0) begin
                    r_x <= w_nextX;
                end else begin
                    r_k <= r_k - 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = w_outValid;
    assign bus.busy      = w_busy;
    assign bus.x_arr     = r_x;
endmodule

// File: tb/tb_vec_logit.sv
// Self-checking bench for vec_logit: scoreboard of golden logits plus directed latency/saturation/backpressure/reset cases.
// Golden model: integer sigmoid curve and a plain binary search for the largest x with sigmoid(x) <= y.
module tb_vec_logit;
    localparam int W = 4;
    localparam int N = 16;
    localparam int R = 8;
`ifdef VEC_LOGIT_BACK2BACK_EN
    localparam int PERIOD = N + 1;
`else
    localparam int PERIOD = N + 2;
`endif

    logic clock;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;

    vec_logit_if #(.W(W), .N(N)) bus ();

    vec_logit #(.W(W), .N(N), .R(R)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [W-1:0][N-1:0] expQ[$];
    int                  accQ[$];
    int                  popCycles[$];
    bit                  newResult;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    // Reference sigmoid with R=8: 1.0 = 256, breakpoints at 1.0, 2.0 and 4.0
    function automatic int goldSig(input int x);
        int a;
        int f;
        a = (x < 0) ? -x : x;
        if (a < 256)       f = 128 + a / 4;
        else if (a < 512)  f = 192 + (a - 256) / 8;
        else if (a < 1024) f = 224 + (a - 512) / 16;
        else               f = 256;
        return (x < 0) ? 256 - f : f;
    endfunction

    function automatic int goldLogit(input int y);
        int lo;
        int hi;
        int mid;
        if (goldSig(-32768) > y) return -32768;
        lo = -32768;
        hi = 32768;
        while (hi - lo > 1) begin
            mid = lo + (hi - lo) / 2;
            if (goldSig(mid) <= y) lo = mid;
            else                   hi = mid;
        end
        return lo;
    endfunction

    function automatic logic [W-1:0][N-1:0] goldVec(input logic [W-1:0][N-1:0] y);
        logic [W-1:0][N-1:0] r;
        for (int i = 0; i < W; i++) r[i] = N'(goldLogit(int'($signed(y[i]))));
        return r;
    endfunction

    function automatic int lane(input logic [W-1:0][N-1:0] v, input int i);
        return int'($signed(v[i]));
    endfunction

    // Compare process: every cycle a result is presented it must match the oldest accepted vector
    always @(negedge clock) begin
        if (reset) begin
            expQ.delete();
            accQ.delete();
            newResult = 1'b1;
        end else begin
            if (bus.out_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedOut", 1, 0);
                end else begin
                    for (int i = 0; i < W; i++)
                        checkOutput($sformatf("xLane%0d", i), lane(bus.x_arr, i), lane(expQ[0], i));
                    if (newResult) begin
                        checkOutput("latency", cyc - accQ[0], N + 1);
                        newResult = 1'b0;
                    end
                    if (bus.out_ready) begin
                        void'(expQ.pop_front());
                        void'(accQ.pop_front());
                        popCycles.push_back(cyc);
                        newResult = 1'b1;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                expQ.push_back(goldVec(bus.y_arr));
                accQ.push_back(cyc);
            end
        end
    end

    task automatic applyStimulus(input logic [W-1:0][N-1:0] y);
        bit got;
        got = 1'b0;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b1;
        bus.y_arr    = y;
        for (int t = 0; t < 60; t++) begin
            @(negedge clock);
            if (bus.in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) checkOutput("acceptTimeout", 0, 1);
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        for (int i = 0; i < W; i++) bus.y_arr[i] = N'($urandom);
    endtask

    task automatic waitResult(output logic [W-1:0][N-1:0] x);
        bit got;
        got = 1'b0;
        x   = '0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clock);
            if (bus.out_valid) begin
                got = 1'b1;
                x   = bus.x_arr;
                break;
            end
        end
        if (!got) checkOutput("resultTimeout", 0, 1);
    endtask

    function automatic logic [W-1:0][N-1:0] mkVec(input int a, input int b, input int c, input int d);
        logic [W-1:0][N-1:0] v;
        v[0] = N'(a);
        v[1] = N'(b);
        v[2] = N'(c);
        v[3] = N'(d);
        return v;
    endfunction

    logic [W-1:0][N-1:0] xr;
    logic [W-1:0][N-1:0] yv;
    int                  x0s[7];
    int                  x0;
    int                  xv;

    initial begin
        x0s = '{-1024, -256, -1, 0, 1, 255, 1024};
        cyc = 0;
        checks = 0;
        errors = 0;
        newResult = 1'b1;
        reset = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.y_arr     = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("rstInReady", int'(bus.in_ready), 1);
        checkOutput("rstOutValid", int'(bus.out_valid), 0);
        checkOutput("rstBusy", int'(bus.busy), 0);
        checkOutput("rstX", int'(bus.x_arr == '0), 1);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Pin the reference model with hand-derived values
        checkOutput("modelSig0", goldSig(0), 128);
        checkOutput("modelSig4", goldSig(4), 129);
        checkOutput("modelSigM1023", goldSig(-1023), 1);
        checkOutput("modelLogit128", goldLogit(128), 3);
        checkOutput("modelLogit0", goldLogit(0), -1024);
        checkOutput("modelLogit256", goldLogit(256), 32767);

        // Latency / midpoint: sigmoid stays at 128 up to x=3
        applyStimulus(mkVec(128, 128, 128, 128));
        waitResult(xr);
        for (int i = 0; i < W; i++) checkOutput($sformatf("half%0d", i), lane(xr, i), 3);
        @(negedge clock);
        checkOutput("singleCycleValid", int'(bus.out_valid), 0);

        // Round-trip through the forward curve
        for (int v = 0; v < 2; v++) begin
            for (int i = 0; i < W; i++) yv[i] = N'(goldSig(x0s[(v * W + i) % 7]));
            applyStimulus(yv);
            waitResult(xr);
            for (int i = 0; i < W; i++) begin
                x0 = x0s[(v * W + i) % 7];
                xv = lane(xr, i);
                checkOutput($sformatf("rtSig%0d", x0), goldSig(xv), goldSig(x0));
                checkOutput($sformatf("rtGe%0d", x0), int'(xv >= x0), 1);
            end
        end

        // Saturation at both ends
        applyStimulus(mkVec(-5, 0, 256, 32767));
        waitResult(xr);
        checkOutput("satNeg", lane(xr, 0), -32768);
        checkOutput("satZero", lane(xr, 1), -1024);
        checkOutput("satOne", lane(xr, 2), 32767);
        checkOutput("satMax", lane(xr, 3), 32767);

        // Backpressure: result must hold while downstream stalls
        @(posedge clock);
        #1;
        bus.out_ready = 1'b0;
        applyStimulus(mkVec(200, 60, 129, 250));
        waitResult(xr);
        for (int t = 0; t < 5; t++) begin
            @(negedge clock);
            checkOutput("bpStable", int'(bus.x_arr == xr), 1);
            checkOutput("bpInReady", int'(bus.in_ready), 0);
            checkOutput("bpBusy", int'(bus.busy), 1);
            checkOutput("bpOutValid", int'(bus.out_valid), 1);
        end
        @(posedge clock);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        checkOutput("bpIdleInReady", int'(bus.in_ready), 1);
        checkOutput("bpIdleOutValid", int'(bus.out_valid), 0);
        checkOutput("bpIdleBusy", int'(bus.busy), 0);

        // Reset during the eighth search cycle discards the partial result
        applyStimulus(mkVec(100, 140, 180, 220));
        repeat (7) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("midRstInReady", int'(bus.in_ready), 1);
        checkOutput("midRstOutValid", int'(bus.out_valid), 0);
        checkOutput("midRstBusy", int'(bus.busy), 0);
        checkOutput("midRstX", int'(bus.x_arr == '0), 1);
        applyStimulus(mkVec(10, 130, 240, 255));
        waitResult(xr);

        // Reset wins over a simultaneous request
        @(posedge clock);
        #1;
        reset = 1'b1;
        bus.in_valid = 1'b1;
        bus.y_arr = mkVec(128, 128, 128, 128);
        @(posedge clock);
        #1;
        reset = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clock);
        checkOutput("rstWinsBusy", int'(bus.busy), 0);
        checkOutput("rstWinsInReady", int'(bus.in_ready), 1);

        // Streaming: continuous requests and a ready sink
        popCycles.delete();
        @(posedge clock);
        #1;
        bus.in_valid = 1'b1;
        bus.y_arr = mkVec(50, 128, 170, 255);
        for (int t = 0; t < 300 && popCycles.size() < 5; t++) begin
            bit took;
            @(negedge clock);
            took = bus.in_ready;
            @(posedge clock);
            #1;
            if (took)
                for (int i = 0; i < W; i++) bus.y_arr[i] = N'(int'($urandom_range(0, 330)) - 30);
        end
        bus.in_valid = 1'b0;
        checkOutput("streamCount", int'(popCycles.size() >= 5), 1);
        for (int i = 1; i < popCycles.size(); i++)
            checkOutput("streamPeriod", popCycles[i] - popCycles[i-1], PERIOD);

        for (int t = 0; t < 60 && expQ.size() != 0; t++) @(negedge clock);
        repeat (3) @(negedge clock);
        checkOutput("scoreboardEmpty", expQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vec_logit.md
Name: vec_logit

Overview:
- Multi-cycle vector inverse-sigmoid (logit) unit. Consumes ARR_WIDTH fixed-point probabilities and returns the pre-activation values that the forward vector sigmoid maps onto them.
- Uses per-lane successive-approximation search. Each lane owns one sigmoid_unit instance, so the inverse matches the forward approximation bit-exactly.
- Sits on the gate/activation path for operations that recover logits, e.g. calibration and gate-state inversion.
- Uses a valid/ready handshake on both sides.

Parameters:
- W, default ARR_WIDTH: number of lanes.
- N, default FXP_N: fixed-point word width, sign bit included.
- R, default FXP_R: fraction bits. 1.0 = 2^R.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  y_arr holds a valid vector.
- in_ready  output  1  unit can accept a vector this cycle.
- y_arr  input  W x N signed  target sigmoid values, per lane.
- out_valid  output  1  x_arr holds a completed result.
- out_ready  input  1  downstream accepts x_arr this cycle.
- x_arr  output  W x N signed  logit result, per lane.
- busy  output  1  high in SEARCH or DONE.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high. All state updates occur on the rising edge of clock.
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0, busy = 0.
  - x_arr = 0, internal accumulators = 0, bit counter = N-1.
- Result definition, per lane i: x_arr[i] is the largest signed N-bit x such that sigmoid_unit(x) <= y_arr[i], compared as signed values. If no such x exists, x_arr[i] = -2^(N-1).
- Algorithm, per lane, using offset-binary accumulator u (N bits):
  - On accept: u = 0.
  - For bit k = N-1 down to 0, one bit per cycle: trial = u | (1<<k). Evaluate sigmoid_unit on (trial with MSB inverted). If that output is <= the latched y, set u = trial.
  - Result: x = u with MSB inverted.
  - All lanes step in lockstep and share one counter.
- FSM states:
  - IDLE: in_ready = 1. If in_valid, latch y_arr, clear u, set k = N-1, go to SEARCH.
  - SEARCH: in_ready = 0. Resolve one bit per cycle. On the cycle k = 0 resolves, write x_arr and go to DONE. Otherwise decrement k.
  - DONE: out_valid = 1. x_arr and out_valid stay stable until out_ready. On out_ready, go to IDLE; out_valid drops the next cycle.
- Latency: handshake in cycle 0. SEARCH occupies cycles 1..N. out_valid is first high in cycle N+1. Throughput is one vector per N+2 cycles minimum without the optional feature.
- Input capture: y_arr is sampled only at the accept edge. Later changes to y_arr have no effect on the result.
- Out-of-range inputs:
  - Negative y, or y below sigmoid_unit(-2^(N-1)): result is -2^(N-1).
  - y >= sigmoid_unit(2^(N-1)-1): result is 2^(N-1)-1.
- out_ready while not DONE: ignored.
- Reset mid-operation: reset asserted in any state returns to IDLE on the next edge. The partial result is discarded and out_valid = 0.
- Simultaneous reset and in_valid: reset wins. Nothing is accepted.

Optional Feature:
- VEC_LOGIT_BACK2BACK_EN defined:
  - in_ready = (state == IDLE) || (state == DONE && out_ready).
  - A new vector accepted in DONE while the current result retires goes directly to SEARCH. x_arr is overwritten only at the end of the new search.
  - Sustained throughput becomes one vector per N+1 cycles.
- Undefined: in_ready is high only in IDLE. Behaviour is exactly as above.

Test Plan:
- Bench setup: N=16, R=8 (1.0 = 256), W=ARR_WIDTH. Golden model is a scalar sigmoid_unit plus a software search.
- Latency: y_arr all 128 (0.5), in_valid pulse in cycle 0, out_ready=1 -> out_valid first high in cycle 17, single cycle. x_arr equals the golden value. Expect 0 if sigmoid_unit(0)=128 and sigmoid_unit(1)>128.
- Round-trip: per lane, x0 in {-1024, -256, -1, 0, 1, 255, 1024}, y = sigmoid_unit(x0) -> sigmoid_unit(x_arr[i]) == y, and x_arr[i] >= x0.
- Saturation: lane 0 y=-5, lane 1 y=0, lane 2 y=256, lane 3 y=32767 -> lane 0 = -32768. Lane 3 = 32767. Lanes 1 and 2 match the golden model.
- Backpressure: out_ready held low 5 cycles after out_valid -> x_arr stable, in_ready=0, busy=1. Release -> IDLE next cycle, in_ready=1.
- Reset mid-search: reset in SEARCH cycle 8 -> next cycle state IDLE, out_valid=0, in_ready=1, x_arr=0. A fresh vector then completes with correct latency.
- Back-to-back, with VEC_LOGIT_BACK2BACK_EN: continuous in_valid and out_ready -> results every 17 cycles, in order. Without the macro: every 18 cycles.
